key_load_ctrl: RTL



---
 rtl/key_ctrl_pkg.sv | 14 +
 rtl/key_load_ctrl_if.sv | 22 ++
 rtl/key_shift_reg.sv | 27 ++
 rtl/key_load_ctrl.sv | 100 ++++++++++
 4 files changed

// File: rtl/key_ctrl_pkg.sv
// key_ctrl_pkg: state encoding and defaults shared by key_load_ctrl and its interface.
// The PAR, ERR and LOCKOUT encodings are only reached when KEY_PARITY_CHECK_EN is defined.
package key_ctrl_pkg;
    localparam logic [2:0] IDLE    = 3'd0;
    localparam logic [2:0] SHIFT   = 3'd1;
    localparam logic [2:0] PAR     = 3'd2;
    localparam logic [2:0] ARMED   = 3'd3;
    localparam logic [2:0] ERR     = 3'd4;
    localparam logic [2:0] LOCKOUT = 3'd5;
    localparam int KEY_W_DEF    = 64;
    localparam int FAIL_MAX_DEF = 3;
    // Even parity: the parity bit equals the XOR of all key bits.
    localparam logic PAR_ODD = 1'b0;
endpackage

// File: rtl/key_load_ctrl_if.sv
// key_load_ctrl_if: key-provisioning port and key-pin bundle (master = provisioning side).
interface key_load_ctrl_if import key_ctrl_pkg::*; #(
    parameter int KEY_W = KEY_W_DEF
);
    logic             load_start;
    logic             key_bit;
    logic             key_valid;
    logic             key_ready;
    logic [KEY_W-1:0] key_out;
    logic             key_armed;
    logic             busy;
    logic             err;
    logic             lockout;
    modport master (
        output load_start, key_bit, key_valid,
        input  key_ready, key_out, key_armed, busy, err, lockout
    );
    modport slave (
        input  load_start, key_bit, key_valid,
        output key_ready, key_out, key_armed, busy, err, lockout
    );
endinterface

// File: rtl/key_shift_reg.sv
// key_shift_reg: serial-in key register with sync clear; o_d is the value loaded at the next edge.
// The parity output exists only when KEY_PARITY_CHECK_EN is defined.
module key_shift_reg #(
    parameter int KEY_W = 64
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_clr,
    input  logic             i_en,
    input  logic             i_bit,
    output logic [KEY_W-1:0] o_q,
    output logic [KEY_W-1:0] o_d
`ifdef KEY_PARITY_CHECK_EN
    ,
    output logic             o_par
`endif
);
    logic [KEY_W-1:0] r_q;
    assign o_d = i_clr ? '0 : i_en ? {r_q[KEY_W-2:0], i_bit} : r_q;
    assign o_q = r_q;
`ifdef KEY_PARITY_CHECK_EN
    assign o_par = ^r_q;
`endif
    always_ff @(posedge clk) begin
        r_q <= rst ? '0 : o_d;
    end
endmodule

// File: rtl/key_load_ctrl.sv
// key_load_ctrl: serial logic-locking key loader; drives the key pins only after a complete load.
// Define KEY_PARITY_CHECK_EN to add the parity bit, error counting and permanent lockout.
module key_load_ctrl import key_ctrl_pkg::*; #(
    parameter int KEY_W    = KEY_W_DEF,
    parameter int CNT_W    = 7,
    parameter int FAIL_MAX = FAIL_MAX_DEF
) (
    input  logic            CLK,
    input  logic            RST,
    key_load_ctrl_if.slave  bus
);
    logic [2:0]       r_state;
    logic [2:0]       w_nxt;
    logic [CNT_W-1:0] r_cnt;
    logic [KEY_W-1:0] w_key_q;
    logic [KEY_W-1:0] w_key_d;
    logic [KEY_W-1:0] r_key_out;
    logic             r_armed;
    logic             r_busy;
    logic             w_acc;
    logic             w_clr;
    logic             w_en;
    logic             w_last;

    assign bus.key_ready = (r_state == SHIFT) || (r_state == PAR);
    assign w_acc  = bus.key_valid & bus.key_ready;
    // A restart discards any bit accepted in the same cycle.
    assign w_clr  = bus.load_start & (r_state != LOCKOUT);
    assign w_en   = w_acc & ~bus.load_start & (r_state == SHIFT);
    assign w_last = r_cnt == CNT_W'(KEY_W - 1);

    assign bus.key_out   = r_key_out;
    assign bus.key_armed = r_armed;
    assign bus.busy      = r_busy;

`ifdef KEY_PARITY_CHECK_EN
    localparam int FW = $clog2(FAIL_MAX + 1);
    logic [FW-1:0] r_fail;
    logic [FW-1:0] w_fail_inc;
    logic          w_par;
    logic          w_par_ok;
    logic          r_err;
    logic          r_lock;

    key_shift_reg #(.KEY_W(KEY_W)) u_sr (
        .clk(CLK), .rst(RST), .i_clr(w_clr), .i_en(w_en), .i_bit(bus.key_bit),
        .o_q(w_key_q), .o_d(w_key_d), .o_par(w_par)
    );

    assign w_fail_inc = r_fail + 1'b1;
    assign w_par_ok   = bus.key_bit == (w_par ^ PAR_ODD);
    assign w_nxt = w_clr                       ? SHIFT :
                   (w_en && w_last)            ? PAR :
                   (r_state == PAR && w_acc)   ? (w_par_ok ? ARMED :
                                                  (w_fail_inc == FW'(FAIL_MAX)) ? LOCKOUT : ERR) :
                   r_state;
    assign bus.err     = r_err;
    assign bus.lockout = r_lock;

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_fail <= '0;
            r_err  <= 1'b0;
            r_lock <= 1'b0;
        end else begin
            r_fail <= (w_nxt == ARMED) ? '0 :
                      (r_state == PAR && (w_nxt == ERR || w_nxt == LOCKOUT) && r_fail != FW'(FAIL_MAX)) ? w_fail_inc :
                      r_fail;
            r_err  <= w_nxt == ERR;
            r_lock <= w_nxt == LOCKOUT;
        end
    end
`else
    key_shift_reg #(.KEY_W(KEY_W)) u_sr (
        .clk(CLK), .rst(RST), .i_clr(w_clr), .i_en(w_en), .i_bit(bus.key_bit),
        .o_q(w_key_q), .o_d(w_key_d)
    );

    assign w_nxt = w_clr ? SHIFT : (w_en && w_last) ? ARMED : r_state;
    assign bus.err     = 1'b0;
    assign bus.lockout = 1'b0;
`endif

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state   <= IDLE;
            r_cnt     <= '0;
            r_armed   <= 1'b0;
            r_busy    <= 1'b0;
            r_key_out <= '0;
        end else begin
            r_state   <= w_nxt;
            r_cnt     <= w_clr ? '0 : w_en ? r_cnt + 1'b1 : r_cnt;
            r_armed   <= w_nxt == ARMED;
            r_busy    <= (w_nxt == SHIFT) || (w_nxt == PAR);
            // Only a completed key is ever copied onto the key pins.
            r_key_out <= (w_nxt == ARMED) ? (r_state == ARMED ? w_key_q : w_key_d) : '0;
        end
    end
endmodule
